// File: rtl/st_packet_tx.sv
// st_packet_tx: store-and-forward Avalon-ST transmitter that emits only fully committed packets
// Ports: clock/reset (async, active-high); wr_* producer beat port with abort;
// st_* Avalon-ST source (readyLatency 0); pkt_count committed packets queued; drop_count dropped packets
module st_packet_tx #(
    parameter int DATA_W = 128,
    parameter int CH_W   = 8,
    parameter int DEPTH  = 64,
    parameter int PKTQ   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wr_valid,
    input  logic                         wr_last,
    input  logic [CH_W-1:0]              wr_channel,
    input  logic                         wr_abort,
    output logic                         wr_ready,
    output logic [DATA_W-1:0]            st_data,
    output logic                         st_valid,
    output logic                         st_sop,
    output logic                         st_eop,
    output logic [CH_W-1:0]              st_channel,
    input  logic                         st_ready,
    output logic [$clog2(PKTQ+1)-1:0]    pkt_count,
    output logic [15:0]                  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(PKTQ);
    localparam int CW = $clog2(PKTQ+1);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CH_W-1:0] dq_ch [PKTQ];
    logic [AW:0] dq_len [PKTQ];
    logic [AW:0] wr_ptr, cm_ptr, rd_ptr, rd_nxt, len, left;
    logic [QW:0] dq_wi, dq_ri;
    logic up, commit_q, full, desc_full, acc, store, commit, ovf, drop, tx_acc, fin, pop;
    w_state_t w_state, w_next;
    tx_state_t tx_state, tx_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state  <= W_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            w_state  <= w_next;
            tx_state <= tx_next;
        end
    end

    always_comb begin
        w_next  = w_state == W_DROP ? ((wr_abort || (acc && wr_last)) ? W_IDLE : W_DROP)
                : (w_state == W_PKT && wr_abort) ? W_IDLE
                : ovf ? W_DROP
                : store ? (wr_last ? W_IDLE : W_PKT)
                : w_state;
        tx_next = pop ? TX_SEND : fin ? TX_IDLE : tx_state;
    end

    always_comb begin
        full      = (wr_ptr - rd_ptr) == {1'b1, {AW{1'b0}}};
        desc_full = (dq_wi - dq_ri) == {1'b1, {QW{1'b0}}};
        wr_ready  = up && (w_state == W_DROP || (!full && !desc_full));
        acc       = wr_valid && wr_ready;
        store     = acc && (w_state == W_IDLE || (w_state == W_PKT && !wr_abort));
        commit    = store && wr_last;
        // Overflow only when the whole buffer holds the packet in progress and nothing can drain it
        ovf       = w_state == W_PKT && full && cm_ptr == rd_ptr && tx_state == TX_IDLE;
        drop      = w_state == W_PKT && (wr_abort || ovf);
        tx_acc    = tx_state == TX_SEND && st_ready;
        fin       = tx_acc && st_eop;
        pop       = pkt_count != '0 && (tx_state == TX_IDLE || fin);
        rd_nxt    = rd_ptr + (AW+1)'(tx_acc);
    end

    always_ff @(posedge clock) begin
        if (store) mem[wr_ptr[AW-1:0]] <= wr_data;
        if (commit) begin
            dq_ch[dq_wi[QW-1:0]]  <= wr_channel;
            dq_len[dq_wi[QW-1:0]] <= len + ONE;
        end
    end

    // Descriptor becomes visible to pkt_count one cycle after the commit edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up         <= 1'b0;
            commit_q   <= 1'b0;
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            left       <= '0;
            dq_wi      <= '0;
            dq_ri      <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            st_data    <= '0;
            st_valid   <= 1'b0;
            st_sop     <= 1'b0;
            st_eop     <= 1'b0;
            st_channel <= '0;
        end else begin
            up         <= 1'b1;
            commit_q   <= commit;
            wr_ptr     <= drop ? cm_ptr : wr_ptr + (AW+1)'(store);
            cm_ptr     <= commit ? wr_ptr + ONE : cm_ptr;
            len        <= (commit || drop) ? '0 : len + (AW+1)'(store);
            dq_wi      <= dq_wi + (QW+1)'(commit);
            dq_ri      <= dq_ri + (QW+1)'(pop);
            pkt_count  <= pkt_count + CW'(commit_q) - CW'(pop);
            drop_count <= (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            rd_ptr     <= rd_nxt;
            if (pop) begin
                st_valid   <= 1'b1;
                st_sop     <= 1'b1;
                st_eop     <= dq_len[dq_ri[QW-1:0]] == ONE;
                st_channel <= dq_ch[dq_ri[QW-1:0]];
                left       <= dq_len[dq_ri[QW-1:0]] - ONE;
                st_data    <= mem[rd_nxt[AW-1:0]];
            end else if (fin) begin
                st_valid <= 1'b0;
            end else if (tx_acc) begin
                st_sop  <= 1'b0;
                st_eop  <= left == ONE;
                left    <= left - ONE;
                st_data <= mem[rd_nxt[AW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_st_packet_tx.sv
// tb_st_packet_tx: directed self-checking bench for st_packet_tx with an 8-entry beat buffer
module tb_st_packet_tx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [127:0] wr_data = '0;
    logic wr_valid = 1'b0, wr_last = 1'b0, wr_abort = 1'b0, wr_ready;
    logic [7:0] wr_channel = '0;
    logic [127:0] st_data;
    logic st_valid, st_sop, st_eop;
    logic [7:0] st_channel;
    logic st_ready = 1'b1;
    logic [3:0] pkt_count;
    logic [15:0] drop_count;
    int n_cmp = 0, n_bad = 0;
    logic [127:0] exp_q [$];
    logic [127:0] pkt7 [7];

    st_packet_tx #(.DATA_W(128), .CH_W(8), .DEPTH(8), .PKTQ(8)) dut (
        .clock(clock), .reset(reset),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_channel(wr_channel),
        .wr_abort(wr_abort), .wr_ready(wr_ready),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
        .st_channel(st_channel), .st_ready(st_ready),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_beat(logic [127:0] d, logic last, logic [7:0] ch, inout int stalls);
        int w;
        w = 0;
        wr_data = d;
        wr_last = last;
        wr_channel = ch;
        wr_valid = 1'b1;
        @(negedge clock);
        while (!wr_ready && w < 50) begin
            w++;
            @(negedge clock);
        end
        if (!wr_ready) chk("wr_ready timeout", wr_ready, 1);
        stalls += w;
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic wr_pkt(int n, logic [7:0] ch, int seed, bit push, bit term, output int stalls);
        logic [127:0] d;
        stalls = 0;
        for (int j = 0; j < n; j++) begin
            d = (seed == 0) ? pkt7[j] : {32'(seed), 64'h0, 32'(j)};
            wr_beat(d, term && j == n - 1, ch, stalls);
            if (push) exp_q.push_back(d);
        end
    endtask

    task automatic collect(int n, logic [7:0] ch, bit bp, output int cyc);
        int j, k;
        bit held;
        logic [127:0] hd, e;
        logic [3:0] pat;
        j = 0; k = 0; held = 0; hd = '0; pat = 4'b1001; cyc = 0;
        while (j < n && cyc < 200) begin
            st_ready = bp ? pat[k % 4] : 1'b1;
            k++;
            @(negedge clock);
            cyc++;
            if (held && st_valid) chk("held data", st_data, hd);
            if (st_valid && st_ready) begin
                e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                chk("data", st_data, e);
                chk("sop", st_sop, j == 0);
                chk("eop", st_eop, j == n - 1);
                chk("channel", st_channel, ch);
                j++;
                held = 0;
            end else begin
                held = st_valid;
                hd = st_data;
            end
            step();
        end
        if (j < n) chk("beats delivered", j, n);
        st_ready = 1'b1;
    endtask

    initial begin
        int st, cyc, b, w, v;
        pkt7[0] = 128'h004e46324302004e4632430208004500;
        pkt7[1] = 128'h11111111222222223333333344444444;
        pkt7[2] = 128'h55555555666666667777777788888888;
        pkt7[3] = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
        pkt7[4] = 128'hddddddddeeeeeeeeffffffff00000001;
        pkt7[5] = 128'h0123456789abcdef0fedcba987654321;
        pkt7[6] = 128'h363738393A3B3C3D3E3F957C090BFD07;
        repeat (2) @(negedge clock);
        chk("reset st_valid", st_valid, 0);
        chk("reset st_sop", st_sop, 0);
        chk("reset st_eop", st_eop, 0);
        chk("reset st_data", st_data, 0);
        chk("reset st_channel", st_channel, 0);
        chk("reset pkt_count", pkt_count, 0);
        chk("reset drop_count", drop_count, 0);
        chk("reset wr_ready", wr_ready, 0);
        reset = 1'b0;
        #1 chk("wr_ready before first edge", wr_ready, 0);
        step();
        chk("wr_ready after release", wr_ready, 1);

        wr_pkt(7, 8'd5, 0, 1, 1, st);
        chk("single write stalls", st, 0);
        collect(7, 8'd5, 0, cyc);
        chk("single latency and burst cycles", cyc, 9);
        @(negedge clock);
        chk("single st_valid after eop", st_valid, 0);
        chk("single pkt_count after", pkt_count, 0);
        step();

        wr_pkt(7, 8'd5, 0, 1, 1, st);
        collect(7, 8'd5, 1, cyc);
        chk("backpressure queue drained", exp_q.size(), 0);

        st_ready = 1'b0;
        wr_pkt(1, 8'd7, 'h70, 1, 1, st);
        wr_pkt(2, 8'd1, 'h71, 1, 1, st);
        wr_pkt(2, 8'd2, 'h72, 1, 1, st);
        wr_pkt(2, 8'd3, 'h73, 1, 1, st);
        repeat (3) step();
        @(negedge clock);
        chk("b2b pkt_count peak", pkt_count, 3);
        chk("b2b filler valid", st_valid, 1);
        chk("b2b filler channel", st_channel, 7);
        step();
        collect(1, 8'd7, 0, cyc);
        chk("b2b filler cycles", cyc, 1);
        collect(2, 8'd1, 0, cyc);
        chk("b2b ch1 cycles", cyc, 2);
        collect(2, 8'd2, 0, cyc);
        chk("b2b ch2 cycles", cyc, 2);
        collect(2, 8'd3, 0, cyc);
        chk("b2b ch3 cycles", cyc, 2);
        @(negedge clock);
        chk("b2b st_valid after", st_valid, 0);
        chk("b2b pkt_count after", pkt_count, 0);
        step();

        wr_pkt(3, 8'd8, 'h80, 0, 0, st);
        wr_data = 128'hdead;
        wr_valid = 1'b1;
        wr_last = 1'b1;
        wr_abort = 1'b1;
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        wr_abort = 1'b0;
        @(negedge clock);
        chk("abort drop_count", drop_count, 1);
        chk("abort pkt_count", pkt_count, 0);
        step();
        wr_pkt(1, 8'd9, 'h90, 1, 1, st);
        collect(1, 8'd9, 0, cyc);
        chk("abort follow-up cycles", cyc, 3);
        wr_abort = 1'b1;
        step();
        wr_abort = 1'b0;
        @(negedge clock);
        chk("idle abort ignored", drop_count, 1);
        chk("idle abort wr_ready", wr_ready, 1);
        step();

        wr_pkt(12, 8'h11, 'hA0, 0, 1, st);
        chk("overflow stall cycles", st, 1);
        chk("overflow drop_count", drop_count, 2);
        wr_pkt(2, 8'h22, 'hB0, 1, 1, st);
        collect(2, 8'h22, 0, cyc);
        chk("overflow follow-up cycles", cyc, 4);
        chk("overflow drop_count final", drop_count, 2);

        wr_pkt(7, 8'd4, 'hC0, 0, 1, st);
        b = 0;
        w = 0;
        while (b < 4 && w < 50) begin
            @(negedge clock);
            w++;
            if (st_valid) b++;
        end
        chk("reached beat 3", b, 4);
        chk("beat 3 data", st_data, {32'h0C0, 64'h0, 32'd3});
        reset = 1'b1;
        #1;
        chk("mid reset st_valid", st_valid, 0);
        chk("mid reset pkt_count", pkt_count, 0);
        chk("mid reset wr_ready", wr_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        v = 0;
        repeat (10) begin
            @(negedge clock);
            if (st_valid) v++;
        end
        chk("no output after reset", v, 0);
        chk("drop_count after reset", drop_count, 0);
        step();
        wr_pkt(2, 8'd6, 'hD0, 1, 1, st);
        collect(2, 8'd6, 0, cyc);
        chk("post-reset packet cycles", cyc, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/st_packet_tx.md
# st_packet_tx

Store-and-forward Avalon-ST packet transmitter that sources the 128-bit packet stream consumed by `in_fifo_network` (`st_data`/`st_sop`/`st_eop`/`st_valid`/`st_channel`/`st_ready`). A producer (MAC shim or host loader) writes packet beats through a simple valid/ready write port. Only fully committed packets are emitted, so the match network never sees a stalled or truncated packet from the source side. Aborted and oversize packets are discarded and counted.

## Interface

- `DATA_W`, 128, beat width
- `CH_W`, 8, channel width
- `DEPTH`, 64, beat buffer entries; power of two, at least 4
- `PKTQ`, 8, descriptor queue entries (committed packets); power of two

- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `wr_data`  in  DATA_W  beat from the producer
- `wr_valid`  in  1  beat present
- `wr_last`  in  1  beat is the last of its packet; qualified by `wr_valid`
- `wr_channel`  in  CH_W  packet channel; sampled only on the accepted `wr_last` beat
- `wr_abort`  in  1  discard the packet in progress; independent of `wr_valid`
- `wr_ready`  out  1  a beat is accepted when `wr_valid && wr_ready`
- `st_data`  out  DATA_W  output beat
- `st_valid`  out  1  output beat valid
- `st_sop`  out  1  first beat of the packet
- `st_eop`  out  1  last beat of the packet
- `st_channel`  out  CH_W  packet channel; constant for all beats of a packet
- `st_ready`  in  1  sink accepts; readyLatency 0
- `pkt_count`  out  $clog2(PKTQ+1)  committed packets not yet fully popped from the descriptor queue
- `drop_count`  out  16  dropped packets; saturates at 0xFFFF

## Operation

- Beat buffer is circular with three pointers, each one bit wider than the index:
  - `wr_ptr`: next write position
  - `cm_ptr`: end of the last committed packet
  - `rd_ptr`: next beat to transmit
- Full: `wr_ptr - rd_ptr == DEPTH`.
- Write FSM:
  - **W_IDLE / W_PKT:** an accepted beat is written at `wr_ptr`, which then increments; the FSM moves to W_PKT.
  - **Commit:** an accepted beat with `wr_last` pushes descriptor {channel, length = beats} into the descriptor queue, sets `cm_ptr` to the new `wr_ptr`, and returns the FSM to W_IDLE.
  - **Abort:** `wr_abort` in W_PKT sets `wr_ptr` to `cm_ptr`, increments `drop_count` and returns to W_IDLE. Any beat presented in the same cycle is discarded. `wr_abort` in W_IDLE is ignored and not counted. Abort beats `wr_last` in the same cycle.
  - **Overflow:** in W_PKT, when the buffer is full with `cm_ptr == rd_ptr` and the TX side idle, the FSM sets `wr_ptr` to `cm_ptr`, increments `drop_count` and enters W_DROP.
  - **W_DROP:** `wr_ready` = 1. Beats are accepted and discarded through the `wr_last` beat inclusive, then the FSM returns to W_IDLE. `wr_abort` also returns it to W_IDLE, with no extra count.
- `wr_ready` in W_IDLE and W_PKT = !full && !desc_full. This also covers the last beat, so a commit always finds descriptor space.
- TX FSM:
  - **TX_IDLE:** when the descriptor queue is non-empty, pop a descriptor, present beat `rd_ptr` with `st_sop` = 1, `st_eop` = (length == 1) and the descriptor's channel, then go to TX_SEND.
  - **TX_SEND:** hold all `st_*` outputs while `st_valid && !st_ready`. On acceptance, `rd_ptr` increments and the next beat is presented.
  - **End of packet:** on acceptance of the `st_eop` beat, if another descriptor is available, its first beat is presented in the next cycle (back-to-back, no bubble); otherwise `st_valid` drops and the FSM goes to TX_IDLE.
- `pkt_count`: +1 on commit, -1 on descriptor pop; unchanged when both happen in the same cycle.

## Timing

- Reset (asynchronous assert, synchronous release): all pointers, FSMs, `st_data`, `st_valid`, `st_sop`, `st_eop`, `st_channel`, `pkt_count` and `drop_count` go to 0. `wr_ready` is 0 while reset is asserted and 1 from the first edge after release.
- Reset mid-packet, on either side, discards all buffered and in-flight data with no partial output afterward.
- Latency: `wr_last` accepted at edge N with TX_IDLE → `pkt_count` increments at N+1 → `st_valid` = 1 with `st_sop` at N+2.
- Throughput: one beat per cycle with `st_ready` held high, including across packet boundaries.
- `st_data` and `st_channel` are don't-care when `st_valid` = 0, but are held at their last value (no X).
- Freed beat space is visible to `wr_ready` in the cycle after the beat is accepted on the output.

## Test plan

- **Single packet:** write the 7-beat packet whose first beat is 0x004e46324302004e4632430208004500, last beat 0x363738393A3B3C3D3E3F957C090BFD07, channel 5, with `st_ready` = 1 → `st_valid` from N+2 for 7 consecutive cycles, `st_sop` on beat 0 only, `st_eop` on beat 6 only, `st_channel` = 5 throughout, data in order.
- **Backpressure:** same packet with `st_ready` toggling 1,0,0,1,… → each beat is held stable while `st_ready` = 0, no beat is duplicated or skipped, and all 7 beats are delivered.
- **Back-to-back:** three 2-beat packets on channels 1, 2, 3, written before transmission starts → 6 consecutive valid cycles with sop/eop alternating and channels 1,1,2,2,3,3; `pkt_count` peaks at 3 and returns to 0.
- **Abort:** abort after 3 beats, then write a 1-beat packet on channel 9 → only the 1-beat packet is emitted (sop = eop = 1, channel 9); `drop_count` = 1.
- **Overflow:** with `DEPTH` = 8, write a 12-beat packet and then a 2-beat packet → first packet discarded with `wr_ready` high throughout W_DROP; `drop_count` = 1; only the 2-beat packet is emitted.
- **Reset mid-stream:** assert `reset` during beat 3 of a transmit → `st_valid` = 0 immediately, `pkt_count` = 0, and no output until a new packet is committed.
